// File: rtl/stm32_bus_master.sv
// rtl/stm32_bus_master.sv - byte-wide command bus master with SYNC marker and divided bus clock
//
// Ports:
//   clk_in, reset_n        system clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake; cmd_ready is high only while idle
//   cmd_code[2:0]          0 test, 1 params write, 2 status read, 3 TX IQ write,
//                          4 RX IQ read, 5 audio PLL on, 6 audio PLL off, 7 reserved
//   param_in[103:0]        13 parameter bytes, [103:96] goes out first
//   txiq_in[63:0]          {Q[31:0], I[31:0]}, Q MSB byte goes out first
//   test_in[7:0]           byte for the bus echo test
//   rd_data[127:0]         captured read bytes, first captured byte in [127:120]
//   cmd_done, cmd_error    one-cycle completion / code-7 rejection pulses
//   BUS_CLK, DATA_SYNC     bus clock and command-phase marker to the responder
//   DATA_BUS[7:0]          bidirectional byte bus, high-Z whenever the block is not driving

module stm32_bus_master #(
    parameter int CLK_DIV = 4
) (
    input  logic         clk_in,
    input  logic         reset_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_code,
    input  logic [103:0] param_in,
    input  logic [63:0]  txiq_in,
    input  logic [7:0]   test_in,
    output logic [127:0] rd_data,
    output logic         cmd_done,
    output logic         cmd_error,
    output logic         BUS_CLK,
    output logic         DATA_SYNC,
    inout  wire  [7:0]   DATA_BUS
);

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_XFER, S_DONE} state_t;

    localparam logic [8:0] PH_HIGH = 9'(CLK_DIV);
    localparam logic [8:0] PH_LAST = 9'(2 * CLK_DIV - 1);

    state_t         r_state;
    state_t         w_next;
    logic [8:0]     r_phase;
    logic [4:0]     r_byte;
    logic [2:0]     r_code;
    logic [103:0]   r_param;
    logic [63:0]    r_txiq;
    logic [7:0]     r_test;
    logic [127:0]   r_rd;
    logic           r_cmd_error;

    logic [4:0]     w_n_bytes;
    logic           w_last_phase;
    logic           w_high;
    logic           w_last_byte;
    logic           w_accept;
    logic           w_reject;
    logic           w_oe;
    logic [7:0]     w_dout;
    logic           w_capture;
    logic [6:0]     w_rd_msb;
    logic [6:0]     w_par_msb;
    logic [5:0]     w_tx_msb;

    assign w_accept     = (r_state == S_IDLE) && cmd_valid && (cmd_code != 3'd7);
    assign w_reject     = (r_state == S_IDLE) && cmd_valid && (cmd_code == 3'd7);
    assign w_last_phase = (r_phase == PH_LAST);
    assign w_high       = (r_phase >= PH_HIGH);
    assign w_last_byte  = (r_byte == w_n_bytes - 5'd1);

    // Byte lanes for the current payload period; r_byte is the 0-based period index.
    assign w_par_msb = 7'd103 - {r_byte[3:0], 3'b000};
    assign w_tx_msb  = 6'd63 - {r_byte[2:0], 3'b000};
    // The echo test only ever captures one byte, always into the top lane.
    assign w_rd_msb  = (r_code == 3'd0) ? 7'd127 : (7'd127 - {r_byte[3:0], 3'b000});

    always_comb begin
        w_n_bytes = 5'd0;
        case (r_code)
            3'd0:    w_n_bytes = 5'd2;
            3'd1:    w_n_bytes = 5'd13;
            3'd2:    w_n_bytes = 5'd5;
            3'd3:    w_n_bytes = 5'd8;
            3'd4:    w_n_bytes = 5'd16;
            default: w_n_bytes = 5'd0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_SYNC;
            S_SYNC: if (w_last_phase) w_next = (w_n_bytes == 5'd0) ? S_DONE : S_XFER;
            S_XFER: if (w_last_phase && w_last_byte) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_oe      = 1'b0;
        w_dout    = 8'h00;
        w_capture = 1'b0;
        case (r_state)
            S_SYNC: begin
                w_oe   = 1'b1;
                w_dout = {5'b00000, r_code};
            end
            S_XFER: begin
                case (r_code)
                    3'd0: begin
                        if (r_byte == 5'd0) begin
                            // Drop the bus after the first high cycle: the responder
                            // starts echoing from the BUS_CLK rising edge.
                            w_oe   = (r_phase <= PH_HIGH);
                            w_dout = r_test;
                        end else begin
                            w_capture = w_last_phase;
                        end
                    end
                    3'd1: begin
                        w_oe   = 1'b1;
                        w_dout = r_param[w_par_msb -: 8];
                    end
                    3'd3: begin
                        w_oe   = 1'b1;
                        w_dout = r_txiq[w_tx_msb -: 8];
                    end
                    3'd2, 3'd4: w_capture = w_last_phase;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_phase     <= 9'd0;
            r_byte      <= 5'd0;
            r_cmd_error <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cmd_error <= w_reject;
            if (r_state == S_SYNC || r_state == S_XFER) begin
                r_phase <= w_last_phase ? 9'd0 : r_phase + 9'd1;
            end else begin
                r_phase <= 9'd0;
            end
            if (r_state == S_XFER) begin
                if (w_last_phase) r_byte <= r_byte + 5'd1;
            end else begin
                r_byte <= 5'd0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_code  <= 3'd0;
            r_param <= 104'd0;
            r_txiq  <= 64'd0;
            r_test  <= 8'd0;
            r_rd    <= 128'd0;
        end else begin
            if (w_accept) begin
                r_code  <= cmd_code;
                r_param <= param_in;
                r_txiq  <= txiq_in;
                r_test  <= test_in;
                if (cmd_code == 3'd0 || cmd_code == 3'd2 || cmd_code == 3'd4) begin
                    r_rd <= 128'd0;
                end
            end
            if (w_capture) begin
                r_rd[w_rd_msb -: 8] <= DATA_BUS;
            end
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign cmd_done  = (r_state == S_DONE);
    assign cmd_error = r_cmd_error;
    assign rd_data   = r_rd;
    assign BUS_CLK   = (r_state == S_SYNC || r_state == S_XFER) && w_high;
    assign DATA_SYNC = (r_state == S_SYNC);
    assign DATA_BUS  = w_oe ? w_dout : 8'hzz;

endmodule

// File: tb/tb_stm32_bus_master.sv
// tb/tb_stm32_bus_master.sv - table-driven scoreboard bench for stm32_bus_master
`timescale 1ns/1ps

module tb_stm32_bus_master;

    localparam int CLK_DIV = 4;

    logic         clk_in = 1'b0;
    logic         reset_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_code = 3'd0;
    logic [103:0] param_in = 104'd0;
    logic [63:0]  txiq_in = 64'd0;
    logic [7:0]   test_in = 8'd0;
    logic [127:0] rd_data;
    logic         cmd_done;
    logic         cmd_error;
    logic         BUS_CLK;
    logic         DATA_SYNC;
    wire  [7:0]   DATA_BUS;

    stm32_bus_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk_in    (clk_in),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_code  (cmd_code),
        .param_in  (param_in),
        .txiq_in   (txiq_in),
        .test_in   (test_in),
        .rd_data   (rd_data),
        .cmd_done  (cmd_done),
        .cmd_error (cmd_error),
        .BUS_CLK   (BUS_CLK),
        .DATA_SYNC (DATA_SYNC),
        .DATA_BUS  (DATA_BUS)
    );

    always #5 clk_in = ~clk_in;

    // Responder: 0 silent, 1 echo the byte seen on edge 2, 2 stream base+k-2 from edge k>=2
    int          resp_mode = 0;
    logic [7:0]  resp_base = 8'h00;
    logic        resp_oe = 1'b0;
    logic [7:0]  resp_val = 8'h00;
    logic        bus_clk_q = 1'b0;
    int          edge_cnt = 0;
    int          rise_total = 0;
    logic [7:0]  edge_byte [0:31];
    logic        edge_sync [0:31];

    assign DATA_BUS = resp_oe ? resp_val : 8'hzz;

    always @(negedge clk_in) begin
        if (!reset_n || cmd_done) resp_oe = 1'b0;
        if (BUS_CLK && !bus_clk_q) begin
            rise_total = rise_total + 1;
            if (DATA_SYNC) edge_cnt = 1;
            else           edge_cnt = edge_cnt + 1;
            if (edge_cnt < 32) begin
                edge_byte[edge_cnt] = DATA_BUS;
                edge_sync[edge_cnt] = DATA_SYNC;
            end
            if (resp_mode == 1 && edge_cnt == 2) begin
                resp_val = DATA_BUS;
                resp_oe  = 1'b1;
            end
            if (resp_mode == 2 && edge_cnt >= 2) begin
                resp_val = resp_base + 8'(edge_cnt - 2);
                resp_oe  = 1'b1;
            end
        end
        bus_clk_q = BUS_CLK;
    end

    typedef struct {
        logic [2:0]   code;
        logic [103:0] param;
        logic [63:0]  txiq;
        logic [7:0]   test;
        int           mode;
        logic [7:0]   base;
        int           hold;
        int           exp_lat;
        int           exp_edges;
    } vec_t;

    typedef struct {
        int           lat;
        int           edges;
        logic [127:0] rd;
    } exp_t;

    vec_t         tbl [8];
    exp_t         exp_q [$];
    logic [127:0] model_rd = 128'd0;
    int           n_cmp = 0;
    int           n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int n_of(input logic [2:0] c);
        case (c)
            3'd0: return 2;
            3'd1: return 13;
            3'd2: return 5;
            3'd3: return 8;
            3'd4: return 16;
            default: return 0;
        endcase
    endfunction

    function automatic int n_writes(input logic [2:0] c);
        case (c)
            3'd0: return 1;
            3'd1: return 13;
            3'd3: return 8;
            default: return 0;
        endcase
    endfunction

    function automatic logic [7:0] wr_model(input vec_t v, input int j);
        logic [103:0] p;
        logic [63:0]  t;
        case (v.code)
            3'd1: begin p = v.param >> (8 * (12 - j)); return p[7:0]; end
            3'd3: begin t = v.txiq >> (8 * (7 - j)); return t[7:0]; end
            default: return v.test;
        endcase
    endfunction

    function automatic logic [127:0] rd_model(input vec_t v, input logic [127:0] prev);
        logic [127:0] r;
        int n;
        n = n_of(v.code);
        r = 128'd0;
        case (v.code)
            3'd0: return {v.test, 120'd0};
            3'd2, 3'd4: begin
                for (int i = 0; i < n; i++) r = (r << 8) | 128'(8'(v.base + 8'(i)));
                return r << (8 * (16 - n));
            end
            default: return prev;
        endcase
    endfunction

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   cyc;
        int   rise0;
        int   drv_err;
        int   wr_err;
        bit   seen;
        e.lat    = v.exp_lat;
        e.edges  = v.exp_edges;
        model_rd = rd_model(v, model_rd);
        e.rd     = model_rd;
        exp_q.push_back(e);

        resp_mode = v.mode;
        resp_base = v.base;
        cmd_code  = v.code;
        param_in  = v.param;
        txiq_in   = v.txiq;
        test_in   = v.test;
        cmd_valid = 1'b1;
        rise0     = rise_total;
        drv_err   = 0;
        chk($sformatf("ready_c%0d", v.code), cmd_ready, 1);
        @(posedge clk_in); #2;
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 400) begin
            if (cyc < v.hold) begin
                cmd_code = 3'd1;
                txiq_in  = ~v.txiq;
            end else begin
                cmd_valid = 1'b0;
            end
            if ((v.code == 3'd2 || v.code == 3'd4) && resp_oe && !DATA_SYNC && DATA_BUS !== resp_val)
                drv_err++;
            if (cmd_done) seen = 1;
            else begin
                @(posedge clk_in); #2;
                cyc++;
            end
        end
        cmd_valid = 1'b0;

        e = exp_q.pop_front();
        chk($sformatf("done_seen_c%0d", v.code), seen, 1);
        chk($sformatf("latency_c%0d", v.code), cyc + 1, e.lat);
        chk($sformatf("edges_c%0d", v.code), rise_total - rise0, e.edges);
        chk($sformatf("rd_data_c%0d", v.code), rd_data, e.rd);
        chk($sformatf("sync_byte_c%0d", v.code), {edge_sync[1], edge_byte[1]}, {1'b1, 5'b00000, v.code});
        if (n_of(v.code) > 0)
            chk($sformatf("sync_low_c%0d", v.code), edge_sync[2], 0);
        if (n_writes(v.code) > 0) begin
            wr_err = 0;
            for (int j = 0; j < n_writes(v.code); j++) begin
                if (edge_byte[j + 2] !== wr_model(v, j)) begin
                    wr_err++;
                    $display("FAIL wr_byte_c%0d_%0d: got %0h expected %0h", v.code, j, edge_byte[j + 2], wr_model(v, j));
                end
            end
            chk($sformatf("wr_bytes_c%0d", v.code), wr_err, 0);
        end
        if (v.code == 3'd2 || v.code == 3'd4)
            chk($sformatf("no_drive_c%0d", v.code), drv_err, 0);
        @(posedge clk_in); #2;
        chk($sformatf("done_pulse_c%0d", v.code), cmd_done, 0);
        chk($sformatf("idle_after_c%0d", v.code), cmd_ready, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        int rise0;
        int dones;
        vec_t v;

        tbl[0] = '{3'd0, 104'd0, 64'd0, 8'hA5, 1, 8'h00, 0, 25, 3};
        tbl[1] = '{3'd1, 104'h0102030405060708090A0B0C0D, 64'd0, 8'h00, 0, 8'h00, 0, 113, 14};
        tbl[2] = '{3'd2, 104'd0, 64'd0, 8'h00, 2, 8'h81, 0, 49, 6};
        tbl[3] = '{3'd3, 104'hEEEEEEEEEEEEEEEEEEEEEEEEEE, 64'h1122334455667788, 8'h00, 0, 8'h00, 40, 73, 9};
        tbl[4] = '{3'd4, 104'd0, 64'd0, 8'h00, 2, 8'h10, 0, 137, 17};
        tbl[5] = '{3'd5, 104'd0, 64'd0, 8'h00, 0, 8'h00, 0, 9, 1};
        tbl[6] = '{3'd6, 104'd0, 64'd0, 8'h00, 0, 8'h00, 0, 9, 1};
        tbl[7] = '{3'd0, 104'd0, 64'd0, 8'h3C, 1, 8'h00, 0, 25, 3};

        // reset state
        repeat (3) @(posedge clk_in);
        #2;
        chk("rst_ready", cmd_ready, 1);
        chk("rst_bus_clk", BUS_CLK, 0);
        chk("rst_sync", DATA_SYNC, 0);
        chk("rst_done", cmd_done, 0);
        chk("rst_error", cmd_error, 0);
        chk("rst_rd_data", rd_data, 0);
        reset_n = 1'b1;
        @(posedge clk_in); #2;

        // reserved code rejected, no bus activity
        rise0     = rise_total;
        cmd_code  = 3'd7;
        cmd_valid = 1'b1;
        @(posedge clk_in); #2;
        cmd_valid = 1'b0;
        chk("err_pulse", cmd_error, 1);
        chk("err_still_idle", cmd_ready, 1);
        @(posedge clk_in); #2;
        chk("err_one_cycle", cmd_error, 0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_done) dones++;
            @(posedge clk_in); #2;
        end
        chk("err_no_edges", rise_total - rise0, 0);
        chk("err_no_done", dones, 0);

        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        // reset during byte 3 of a status read
        resp_mode = 2;
        resp_base = 8'h40;
        cmd_code  = 3'd2;
        cmd_valid = 1'b1;
        @(posedge clk_in); #2;
        cmd_valid = 1'b0;
        cyc = 0;
        while (edge_cnt != 4 && cyc < 200) begin
            @(posedge clk_in); #2;
            cyc++;
        end
        chk("abort_reach_byte3", edge_cnt, 4);
        @(posedge clk_in); #2;
        chk("abort_rd_partial", rd_data, {8'h40, 8'h41, 112'd0});
        reset_n = 1'b0;
        #1;
        chk("abort_bus_clk", BUS_CLK, 0);
        chk("abort_sync", DATA_SYNC, 0);
        chk("abort_rd_data", rd_data, 0);
        chk("abort_idle", cmd_ready, 1);
        chk("abort_not_driving", DATA_BUS, resp_val);
        model_rd  = 128'd0;
        dones     = 0;
        resp_mode = 0;
        cmd_code  = 3'd5;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (cmd_done) dones++;
            @(posedge clk_in); #2;
        end
        reset_n = 1'b1;
        @(posedge clk_in); #2;
        chk("first_edge_accept", DATA_SYNC, 1);
        cmd_valid = 1'b0;
        cyc = 0;
        while (!cmd_done && cyc < 100) begin
            @(posedge clk_in); #2;
            cyc++;
        end
        chk("abort_no_done", dones, 0);
        chk("post_reset_latency", cyc + 1, 9);
        @(posedge clk_in); #2;

        v = tbl[2];
        run_vec(v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stm32_bus_master.md
STM32_BUS_MASTER -- requirements
Module: stm32_bus_master

Interface
REQ-001 Parameter CLK_DIV, default 4, clk_in cycles per BUS_CLK half-period; legal range 2..255.
REQ-002 clk_in  in  1  system clock; all logic is clocked on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out  1  block can accept a command.
REQ-006 cmd_code  in  3  bus command: 0 test, 1 params write, 2 status read, 3 TX IQ write, 4 RX IQ read, 5 audio PLL on, 6 audio PLL off, 7 reserved.
REQ-007 param_in  in  104  13 parameter bytes; [103:96] is sent first.
REQ-008 txiq_in  in  64  Q[31:0] in [63:32] and I[31:0] in [31:0]; Q MSB byte is sent first.
REQ-009 test_in  in  8  bus-test byte.
REQ-010 rd_data  out  128  captured read bytes; the first byte captured lands in [127:120].
REQ-011 cmd_done  out  1  one-cycle pulse when a command completes.
REQ-012 cmd_error  out  1  one-cycle pulse when code 7 is rejected.
REQ-013 BUS_CLK  out  1  bus clock to the responder.
REQ-014 DATA_SYNC  out  1  command-phase marker.
REQ-015 DATA_BUS  inout  8  bidirectional byte bus; the block drives it only while internal OE=1, otherwise it is high-Z.

Function
REQ-016 FSM states: IDLE, SYNC, XFER, DONE; cmd_ready=1 only in IDLE.
REQ-017 Bus period: BUS_CLK low for CLK_DIV cycles, then high for CLK_DIV cycles; the responder acts on each BUS_CLK rising edge.
REQ-018 IDLE: BUS_CLK=0, DATA_SYNC=0, OE=0; BUS_CLK stays low (no free-running clock).
REQ-019 In IDLE, cmd_valid=1 with code 0-6 latches cmd_code, param_in, txiq_in and test_in, then enters SYNC on the next cycle.
REQ-020 In IDLE, cmd_valid=1 with code 7 pulses cmd_error the next cycle and the FSM stays in IDLE.
REQ-021 SYNC lasts one bus period: DATA_SYNC=1, OE=1, DATA_BUS={5'b0,code}; at the end of the period DATA_SYNC=0 and the FSM enters XFER.
REQ-022 Payload periods N per code: 0→2, 1→13, 2→5, 3→8, 4→16, 5/6→0; if N=0 the FSM goes directly to DONE.
REQ-023 Write periods (code 1, code 3, and code 0 period 1): OE=1 and the byte is driven from the first low cycle of the period.
REQ-024 Codes 1 and 3 hold the byte through the whole period.
REQ-025 Code 0 period 1 releases OE after the first high cycle, because the responder echoes from that edge.
REQ-026 Read periods (codes 2 and 4, and code 0 period 2): OE=0 for the whole period.
REQ-027 Code 2 or 4 read period j captures DATA_BUS on the last high cycle of that period into rd_data byte j-1.
REQ-028 Code 0 captures DATA_BUS on the last high cycle of period 2 into rd_data[127:120].
REQ-029 For code 2, byte 0 carries OTR flags in bits [1:0]; the block captures the raw byte.
REQ-030 rd_data is cleared to 0 at command accept for codes 0, 2 and 4, and is left unchanged for the other codes.
REQ-031 DONE lasts one cycle: cmd_done=1, then IDLE.
REQ-032 Latency from accept cycle to cmd_done is (1+N)*2*CLK_DIV+1 cycles.
REQ-033 cmd_valid is ignored while cmd_ready=0, and the latched inputs do not change mid-command.
REQ-034 A new command may be accepted in the cycle after DONE.
REQ-035 Responder-side bus release after read-type commands is a system-level timing matter, outside this block.

Reset
REQ-036 reset_n=0 forces IDLE, BUS_CLK=0, DATA_SYNC=0, OE=0, cmd_done=0, cmd_error=0, rd_data=0 and the phase/byte counters to 0, with immediate (asynchronous) effect.
REQ-037 Reset asserted mid-command aborts the command with no cmd_done pulse.
REQ-038 After reset release, the first accept is possible on the first clk_in edge.

Verification
REQ-039 Test: CLK_DIV=4, code 0, test_in=0xA5, responder model echoes → first edge samples 0x00 with SYNC=1, second edge sees 0xA5, rd_data[127:120]=0xA5, cmd_done 25 cycles after accept.
REQ-040 Params write: code 1, param_in bytes 0x01..0x0D → responder samples 0x01..0x0D on edges 2..14, exactly 14 BUS_CLK rising edges, cmd_done at cycle 113.
REQ-041 RX IQ: code 4, responder drives 0x10..0x1F on edges 2..17 → rd_data=0x101112...1F, DATA_BUS never driven by the block after SYNC.
REQ-042 Audio on: code 5 → exactly one BUS_CLK rising edge with DATA_SYNC=1 and DATA_BUS=0x05, cmd_done 9 cycles after accept.
REQ-043 Code 7 → cmd_error pulse, no BUS_CLK edges; cmd_valid held during a code 3 transfer is ignored.
REQ-044 reset_n low during byte 3 of a code 2 read → BUS_CLK, DATA_SYNC and OE go to 0 immediately, rd_data=0, no cmd_done, and the next command completes normally.
